// File: rtl/riscv_snoop_responder.sv
// riscv_snoop_responder: L1 coherency snoop responder (array lookup, MESI downgrade, response, dirty line stream).
// Build option SNOOP_RESP_STATS_EN adds saturating snoop hit/miss counters.
module riscv_snoop_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 5,
  parameter int LINE_WORDS  = 8,
  parameter int WAYS        = 2
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          snoop_valid_i,
  output logic                                          snoop_ready_o,
  input  logic [1:0]                                    snoop_op_i,
  input  logic [ADDR_WIDTH-1:0]                         snoop_addr_i,
  output logic                                          lkp_req_o,
  input  logic                                          lkp_gnt_i,
  output logic [INDEX_BITS-1:0]                         lkp_index_o,
  output logic [ADDR_WIDTH-INDEX_BITS-OFFSET_BITS-1:0]  lkp_tag_o,
  input  logic                                          lkp_hit_i,
  input  logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0]    lkp_way_i,
  input  logic [1:0]                                    lkp_state_i,
  output logic                                          st_we_o,
  output logic [INDEX_BITS-1:0]                         st_index_o,
  output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0]    st_way_o,
  output logic [1:0]                                    st_state_o,
  output logic                                          dat_req_o,
  output logic [$clog2(LINE_WORDS)-1:0]                 dat_word_o,
  input  logic [31:0]                                   dat_rdata_i,
  output logic                                          rsp_valid_o,
  input  logic                                          rsp_ready_i,
  output logic                                          rsp_hit_o,
  output logic                                          rsp_dirty_o,
  output logic                                          wb_valid_o,
  input  logic                                          wb_ready_i,
  output logic [31:0]                                   wb_data_o,
`ifdef SNOOP_RESP_STATS_EN
  output logic [31:0]                                   stat_snoop_hits_o,
  output logic [31:0]                                   stat_snoop_misses_o,
`endif
  output logic                                          wb_last_o
);

  localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int WI    = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    SNOOP_NONE       = 2'd0,
    SNOOP_READ       = 2'd1,
    SNOOP_WRITE      = 2'd2,
    SNOOP_INVALIDATE = 2'd3
  } snoop_op_e;

  typedef enum logic [1:0] {
    ST_I = 2'd0,
    ST_S = 2'd1,
    ST_E = 2'd2,
    ST_M = 2'd3
  } cache_coherency_state_e;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    RESOLVE,
    UPDATE,
    RSP,
    DATA_RD,
    DATA_OUT
  } state_e;

  state_e                 state_q, state_d;
  snoop_op_e              op_q;
  logic [INDEX_BITS-1:0]  index_q;
  logic [TAG_W-1:0]       tag_q;
  logic                   hit_q;
  logic                   dirty_q;
  logic [WW-1:0]          way_q;
  cache_coherency_state_e new_state_q;
  logic [WI-1:0]          word_q;
  logic [31:0]            data_q;
  logic                   rd_pend_q;

  cache_coherency_state_e cur_state;
  cache_coherency_state_e res_next;
  logic                   res_present;
  logic                   res_change;
  logic                   last_word;

  logic unused_addr_bits;
  assign unused_addr_bits = ^snoop_addr_i[OFFSET_BITS-1:0];

  // Snooping never grants ownership: reads demote to S, everything else invalidates.
  function automatic cache_coherency_state_e mesi_next(snoop_op_e op,
                                                      cache_coherency_state_e s);
    if (s == ST_I)           return ST_I;
    else if (op == SNOOP_READ) return ST_S;
    else                     return ST_I;
  endfunction

  always_comb begin
    cur_state   = cache_coherency_state_e'(lkp_state_i);
    res_present = lkp_hit_i && (cur_state != ST_I);
    res_next    = mesi_next(op_q, cur_state);
    res_change  = res_present && (res_next != cur_state);
    last_word   = (word_q == WI'(LINE_WORDS - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      op_q        <= SNOOP_NONE;
      index_q     <= '0;
      tag_q       <= '0;
      hit_q       <= 1'b0;
      dirty_q     <= 1'b0;
      way_q       <= '0;
      new_state_q <= ST_I;
      word_q      <= '0;
      data_q      <= '0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (snoop_valid_i) begin
            op_q    <= snoop_op_e'(snoop_op_i);
            index_q <= snoop_addr_i[OFFSET_BITS +: INDEX_BITS];
            tag_q   <= snoop_addr_i[ADDR_WIDTH-1 -: TAG_W];
            hit_q   <= 1'b0;
            dirty_q <= 1'b0;
          end
        end
        RESOLVE: begin
          hit_q       <= res_present;
          dirty_q     <= res_present && (cur_state == ST_M);
          way_q       <= lkp_way_i;
          new_state_q <= res_next;
        end
        RSP: begin
          if (rsp_ready_i) word_q <= '0;
        end
        DATA_RD: begin
          rd_pend_q <= 1'b1;
        end
        DATA_OUT: begin
          // Read data arrives only in the first DATA_OUT cycle; hold it for backpressure.
          if (rd_pend_q) begin
            data_q    <= dat_rdata_i;
            rd_pend_q <= 1'b0;
          end
          if (wb_ready_i && !last_word) word_q <= word_q + WI'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    snoop_ready_o = 1'b0;
    lkp_req_o     = 1'b0;
    lkp_index_o   = '0;
    lkp_tag_o     = '0;
    st_we_o       = 1'b0;
    st_index_o    = '0;
    st_way_o      = '0;
    st_state_o    = '0;
    dat_req_o     = 1'b0;
    dat_word_o    = '0;
    rsp_valid_o   = 1'b0;
    rsp_hit_o     = 1'b0;
    rsp_dirty_o   = 1'b0;
    wb_valid_o    = 1'b0;
    wb_data_o     = '0;
    wb_last_o     = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          snoop_ready_o = 1'b1;
          if (snoop_valid_i)
            state_d = (snoop_op_e'(snoop_op_i) == SNOOP_NONE) ? RSP : LOOKUP;
        end
        LOOKUP: begin
          lkp_req_o   = 1'b1;
          lkp_index_o = index_q;
          lkp_tag_o   = tag_q;
          if (lkp_gnt_i) state_d = RESOLVE;
        end
        RESOLVE: begin
          state_d = res_change ? UPDATE : RSP;
        end
        UPDATE: begin
          st_we_o    = 1'b1;
          st_index_o = index_q;
          st_way_o   = way_q;
          st_state_o = new_state_q;
          state_d    = RSP;
        end
        RSP: begin
          rsp_valid_o = 1'b1;
          rsp_hit_o   = hit_q;
          rsp_dirty_o = dirty_q;
          if (rsp_ready_i) state_d = dirty_q ? DATA_RD : IDLE;
        end
        DATA_RD: begin
          dat_req_o  = 1'b1;
          dat_word_o = word_q;
          state_d    = DATA_OUT;
        end
        DATA_OUT: begin
          wb_valid_o = 1'b1;
          wb_data_o  = rd_pend_q ? dat_rdata_i : data_q;
          wb_last_o  = last_word;
          if (wb_ready_i) state_d = last_word ? IDLE : DATA_RD;
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef SNOOP_RESP_STATS_EN
  logic [31:0] hits_q, misses_q;
  logic        rsp_done;

  assign rsp_done = (state_q == RSP) && rsp_ready_i && (op_q != SNOOP_NONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if (rsp_done) begin
      if (hit_q) begin
        if (hits_q != '1) hits_q <= hits_q + 32'd1;
      end else begin
        if (misses_q != '1) misses_q <= misses_q + 32'd1;
      end
    end
  end

  assign stat_snoop_hits_o   = hits_q;
  assign stat_snoop_misses_o = misses_q;
`endif

endmodule

// File: tb/tb_riscv_snoop_responder.sv
// Scoreboard bench for riscv_snoop_responder: directed cases then randomized snoops vs a MESI reference model.
module tb_riscv_snoop_responder;

  localparam int AW = 32;
  localparam int IB = 6;
  localparam int OB = 5;
  localparam int LW = 8;
  localparam int TW = AW - IB - OB;
  localparam int WW = 1;
  localparam int WI = 3;

  localparam logic [1:0] OP_NONE  = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_INV   = 2'd3;
  localparam logic [1:0] MS_I = 2'd0;
  localparam logic [1:0] MS_S = 2'd1;
  localparam logic [1:0] MS_E = 2'd2;
  localparam logic [1:0] MS_M = 2'd3;

  logic clk, rst_i;
  logic snoop_valid_i, snoop_ready_o;
  logic [1:0] snoop_op_i;
  logic [AW-1:0] snoop_addr_i;
  logic lkp_req_o, lkp_gnt_i;
  logic [IB-1:0] lkp_index_o;
  logic [TW-1:0] lkp_tag_o;
  logic lkp_hit_i;
  logic [WW-1:0] lkp_way_i;
  logic [1:0] lkp_state_i;
  logic st_we_o;
  logic [IB-1:0] st_index_o;
  logic [WW-1:0] st_way_o;
  logic [1:0] st_state_o;
  logic dat_req_o;
  logic [WI-1:0] dat_word_o;
  logic [31:0] dat_rdata_i;
  logic rsp_valid_o, rsp_ready_i, rsp_hit_o, rsp_dirty_o;
  logic wb_valid_o, wb_ready_i, wb_last_o;
  logic [31:0] wb_data_o;
`ifdef SNOOP_RESP_STATS_EN
  logic [31:0] stat_snoop_hits_o, stat_snoop_misses_o;
`endif

  riscv_snoop_responder #(
    .ADDR_WIDTH(AW), .INDEX_BITS(IB), .OFFSET_BITS(OB), .LINE_WORDS(LW), .WAYS(2)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .snoop_valid_i(snoop_valid_i), .snoop_ready_o(snoop_ready_o),
    .snoop_op_i(snoop_op_i), .snoop_addr_i(snoop_addr_i),
    .lkp_req_o(lkp_req_o), .lkp_gnt_i(lkp_gnt_i),
    .lkp_index_o(lkp_index_o), .lkp_tag_o(lkp_tag_o),
    .lkp_hit_i(lkp_hit_i), .lkp_way_i(lkp_way_i), .lkp_state_i(lkp_state_i),
    .st_we_o(st_we_o), .st_index_o(st_index_o), .st_way_o(st_way_o), .st_state_o(st_state_o),
    .dat_req_o(dat_req_o), .dat_word_o(dat_word_o), .dat_rdata_i(dat_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_hit_o(rsp_hit_o), .rsp_dirty_o(rsp_dirty_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
`ifdef SNOOP_RESP_STATS_EN
    .stat_snoop_hits_o(stat_snoop_hits_o), .stat_snoop_misses_o(stat_snoop_misses_o),
`endif
    .wb_last_o(wb_last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  // Expected-event queues filled by the stimulus, drained by the monitor.
  logic [IB+TW-1:0] exp_lkp[$];
  logic [IB+WW+1:0] exp_st[$];
  logic [1:0]       exp_rsp[$];
  logic [32:0]      exp_wb[$];

  // Array contents the responder presents for the current snoop.
  logic          cur_hit;
  logic [WW-1:0] cur_way;
  logic [1:0]    cur_state;
  logic [31:0]   cur_line[LW];

  int gnt_wait = 0;
  int rsp_wait = 0;
  int wb_mode  = 0;
  bit rand_mode = 1'b0;

  // Reference MESI rule: a snoop read leaves a shared copy, anything else kills the line.
  function automatic logic [1:0] mesi_model(input logic [1:0] op, input logic [1:0] s);
    logic [1:0] after_read[4];
    after_read = '{MS_I, MS_S, MS_S, MS_S};
    return (op == OP_READ) ? after_read[s] : MS_I;
  endfunction

  function automatic logic any_output();
    return |{lkp_req_o, lkp_index_o, lkp_tag_o, st_we_o, st_index_o, st_way_o, st_state_o,
             dat_req_o, dat_word_o, rsp_valid_o, rsp_hit_o, rsp_dirty_o,
             wb_valid_o, wb_data_o, wb_last_o};
  endfunction

  // Array / data / response-sink driver.
  initial begin
    logic gnt_seen, dreq_seen;
    logic [WI-1:0] dword_seen;
    int req_cnt, rsp_cnt;
    req_cnt = 0; rsp_cnt = 0;
    lkp_gnt_i = 1'b0; lkp_hit_i = 1'b0; lkp_way_i = '0; lkp_state_i = '0;
    dat_rdata_i = '0; rsp_ready_i = 1'b0; wb_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      gnt_seen   = lkp_req_o && lkp_gnt_i;
      dreq_seen  = dat_req_o;
      dword_seen = dat_word_o;
      @(posedge clk);
      #1;
      if (gnt_seen) begin
        lkp_hit_i = cur_hit; lkp_way_i = cur_way; lkp_state_i = cur_state;
      end else begin
        lkp_hit_i = 1'($urandom); lkp_way_i = WW'($urandom); lkp_state_i = 2'($urandom);
      end
      dat_rdata_i = dreq_seen ? cur_line[dword_seen] : $urandom;
      if (lkp_req_o) begin
        lkp_gnt_i = rand_mode ? ($urandom_range(0, 2) == 0) : (req_cnt >= gnt_wait);
        req_cnt++;
      end else begin
        lkp_gnt_i = rand_mode ? 1'($urandom) : 1'b0;
        req_cnt = 0;
      end
      if (rsp_valid_o) begin
        rsp_ready_i = rand_mode ? 1'($urandom) : (rsp_cnt >= rsp_wait);
        rsp_cnt++;
      end else begin
        rsp_ready_i = rand_mode ? 1'($urandom) : 1'b0;
        rsp_cnt = 0;
      end
      case (wb_mode)
        0:       wb_ready_i = 1'b1;
        1:       wb_ready_i = ~wb_ready_i;
        default: wb_ready_i = 1'($urandom);
      endcase
    end
  end

  // Monitor: handshakes, hold-under-stall and ready-return checks.
  initial begin
    logic lkp_stall, rsp_stall, wb_stall, ready_next, none_pending;
    logic [IB+TW-1:0] lkp_prev;
    logic [1:0]  rsp_prev, er;
    logic [32:0] wb_prev, ew;
    lkp_stall = 0; rsp_stall = 0; wb_stall = 0; ready_next = 0; none_pending = 0;
    lkp_prev = '0; rsp_prev = '0; wb_prev = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        lkp_stall = 0; rsp_stall = 0; wb_stall = 0; ready_next = 0; none_pending = 0;
        exp_lkp.delete(); exp_st.delete(); exp_rsp.delete(); exp_wb.delete();
      end else begin
        if (ready_next) check("ready_after_done", 64'(snoop_ready_o), 64'd1);
        ready_next = 0;
        if (none_pending)
          check("none_rsp_next_cycle", 64'({rsp_valid_o, rsp_hit_o, rsp_dirty_o}), 64'b100);
        none_pending = snoop_valid_i && snoop_ready_o && (snoop_op_i == OP_NONE);

        if (lkp_stall) check("lkp_hold", 64'({lkp_req_o, lkp_index_o, lkp_tag_o}), 64'({1'b1, lkp_prev}));
        if (lkp_req_o) begin
          if (exp_lkp.size() == 0) fail_evt("lkp_unexpected");
          else if (lkp_gnt_i) check("lkp_fields", 64'({lkp_index_o, lkp_tag_o}), 64'(exp_lkp.pop_front()));
        end
        lkp_stall = lkp_req_o && !lkp_gnt_i;
        lkp_prev  = {lkp_index_o, lkp_tag_o};

        if (st_we_o) begin
          if (exp_st.size() == 0) fail_evt("st_we_unexpected");
          else check("st_write", 64'({st_index_o, st_way_o, st_state_o}), 64'(exp_st.pop_front()));
        end

        if (rsp_stall) check("rsp_hold", 64'({rsp_valid_o, rsp_hit_o, rsp_dirty_o}), 64'({1'b1, rsp_prev}));
        if (rsp_valid_o && rsp_ready_i) begin
          if (exp_rsp.size() == 0) fail_evt("rsp_unexpected");
          else begin
            er = exp_rsp.pop_front();
            check("rsp_hit_dirty", 64'({rsp_hit_o, rsp_dirty_o}), 64'(er));
            if (!er[0]) ready_next = 1;
          end
        end
        rsp_stall = rsp_valid_o && !rsp_ready_i;
        rsp_prev  = {rsp_hit_o, rsp_dirty_o};

        if (wb_stall) check("wb_hold", 64'({wb_valid_o, wb_last_o, wb_data_o}), 64'({1'b1, wb_prev}));
        if (wb_valid_o && wb_ready_i) begin
          if (exp_wb.size() == 0) fail_evt("wb_unexpected");
          else begin
            ew = exp_wb.pop_front();
            check("wb_beat", 64'({wb_last_o, wb_data_o}), 64'(ew));
            if (ew[32]) ready_next = 1;
          end
        end
        wb_stall = wb_valid_o && !wb_ready_i;
        wb_prev  = {wb_last_o, wb_data_o};
      end
    end
  end

  task automatic issue_start(input logic [1:0] op, input logic [AW-1:0] addr,
                             input logic hit, input logic [WW-1:0] way, input logic [1:0] st);
    logic present, dirty;
    logic [1:0] ns;
    int n;
    cur_hit = hit; cur_way = way; cur_state = st;
    present = (op != OP_NONE) && hit && (st != MS_I);
    dirty   = present && (st == MS_M);
    ns      = mesi_model(op, st);
    if (op != OP_NONE) exp_lkp.push_back({addr[OB +: IB], addr[AW-1 -: TW]});
    if (present && ns != st) exp_st.push_back({addr[OB +: IB], way, ns});
    exp_rsp.push_back({present, dirty});
    if (dirty) for (int i = 0; i < LW; i++) exp_wb.push_back({(i == LW - 1), cur_line[i]});
    @(posedge clk);
    #1;
    snoop_valid_i = 1'b1; snoop_op_i = op; snoop_addr_i = addr;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (snoop_ready_o) break;
      n++;
    end
    if (n >= 50) fail_evt("snoop_accept_timeout");
    @(posedge clk);
    #1;
    snoop_valid_i = 1'b0; snoop_op_i = 2'($urandom); snoop_addr_i = $urandom;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (exp_lkp.size() == 0 && exp_st.size() == 0 && exp_rsp.size() == 0 &&
          exp_wb.size() == 0 && snoop_ready_o) break;
      n++;
    end
    if (n >= 400) begin
      fail_evt("transaction_timeout");
      exp_lkp.delete(); exp_st.delete(); exp_rsp.delete(); exp_wb.delete();
    end
  endtask

  task automatic fill_line(input logic [31:0] base, input bit random_fill);
    for (int i = 0; i < LW; i++) cur_line[i] = random_fill ? $urandom : base + 32'(i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_i = 1'b1; snoop_valid_i = 1'b0; snoop_op_i = '0; snoop_addr_i = '0;
    cur_hit = 0; cur_way = '0; cur_state = MS_I;
    fill_line(32'h0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'(any_output()), 64'd0);
    check("reset_ready_low", 64'(snoop_ready_o), 64'd0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("post_reset_ready", 64'(snoop_ready_o), 64'd1);
    check("post_reset_outputs", 64'(any_output()), 64'd0);

    // READ, index 10, way 1 in E: demote to S, clean.
    fill_line(32'h0, 1'b1);
    issue_start(OP_READ, 32'h0000_0140, 1'b1, 1'b1, MS_E);
    wait_done();

    // READ on Modified line: S written and the full line streamed.
    fill_line(32'hA0, 1'b0);
    issue_start(OP_READ, 32'h1234_5660, 1'b1, 1'b0, MS_M);
    wait_done();

    // WRITE miss.
    issue_start(OP_WRITE, 32'hDEAD_BEE0, 1'b0, 1'b1, MS_M);
    wait_done();

    // Backpressure everywhere.
    gnt_wait = 5; rsp_wait = 3; wb_mode = 1;
    fill_line(32'h5000_0000, 1'b1);
    issue_start(OP_INV, 32'h0F0F_0F20, 1'b1, 1'b1, MS_M);
    wait_done();
    gnt_wait = 0; rsp_wait = 0; wb_mode = 0;

    // SNOOP_NONE: no lookup, immediate miss response.
    issue_start(OP_NONE, 32'h0000_0140, 1'b1, 1'b0, MS_M);
    wait_done();

    // Reset while beat 3 is being presented.
    wb_mode = 1;
    fill_line(32'hC0, 1'b0);
    issue_start(OP_READ, 32'h0000_2080, 1'b1, 1'b0, MS_M);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      #2;
      if (wb_valid_o && exp_wb.size() == 5) break;
      n++;
    end
    if (n >= 200) fail_evt("reach_beat3_timeout");
    rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("midreset_wb_valid", 64'(wb_valid_o), 64'd0);
    check("midreset_outputs", 64'(any_output()), 64'd0);
    check("midreset_idle_ready", 64'(snoop_ready_o), 64'd1);
    wb_mode = 0;
    fill_line(32'h0, 1'b1);
    issue_start(OP_READ, 32'h0000_2080, 1'b1, 1'b0, MS_M);
    wait_done();

    // Randomized traffic.
    rand_mode = 1'b1; wb_mode = 2;
    for (int t = 0; t < 40; t++) begin
      fill_line(32'h0, 1'b1);
      issue_start(2'($urandom), $urandom, ($urandom_range(0, 3) != 0), WW'($urandom), 2'($urandom));
      wait_done();
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
